// File: rtl/blackjack_input_pkg.sv
// Shared definitions for the debounced button front end:
// command encodings, FSM states and the key-to-command map.
`ifndef GAMECOMMAND_SVH
`define GAMECOMMAND_SVH
`define gameCommand logic [1:0]
`define COMMAND_NONE 2'b00
`define COMMAND_HIT 2'b01
`define COMMAND_STAND 2'b10
`endif

package blackjack_input_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RELEASE
    } state_t;

    // New commands are mapped to key indices here only.
    function automatic `gameCommand key_to_command(input int idx);
        `gameCommand cmd;
        case (idx)
            0:       cmd = `COMMAND_HIT;
            1:       cmd = `COMMAND_STAND;
            default: cmd = `COMMAND_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/user_input_debounced_key_debouncer.sv
// One active-low button: 2-flop synchroniser, debounce counter,
// debounced level and a one-cycle press pulse.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_pressed,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          pressed_q;
    logic          pressed_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;
    logic          armed_q;
    logic          armed_d;
    logic [1:0]    warm_q;
    logic          raw;

    assign raw = ~sync2_q;

    // Arming only once a released level is seen keeps a key held
    // through reset from producing a press.
    always_comb begin
        cnt_d     = '0;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        armed_d   = armed_q | (warm_q[1] & ~raw & ~pressed_q);
        if (raw != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = raw;
                press_d   = raw & armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            armed_q   <= 1'b0;
            warm_q    <= 2'b00;
        end else begin
            sync1_q   <= i_key_n;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            armed_q   <= armed_d;
            warm_q    <= {warm_q[0], 1'b1};
        end
    end

    assign o_pressed = pressed_q;
    assign o_press   = press_q;

endmodule

// File: rtl/user_input_debounced.sv
// Debounced button-to-command front end with a ready/ack handshake
// towards the game controller; one press yields one command.
module user_input_debounced
    import blackjack_input_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_turnIndicator,
    input  logic [NUM_KEYS-1:0] i_KEY,
    input  logic                i_ack,
    output logic                o_ready,
    output `gameCommand         o_command,
    output logic [NUM_KEYS-1:0] o_keyPressed
);

    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] press;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_key_n  (i_KEY[g]),
            .o_pressed(pressed[g]),
            .o_press  (press[g])
        );
    end

    state_t      state_q;
    state_t      state_d;
    logic        ready_q;
    logic        ready_d;
    `gameCommand cmd_q;
    `gameCommand cmd_d;
    logic        sel_valid;
    `gameCommand sel_cmd;

    // Highest-index mapped press wins; unmapped keys never block others.
    always_comb begin
        sel_valid = 1'b0;
        sel_cmd   = `COMMAND_NONE;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (press[i] && key_to_command(i) != `COMMAND_NONE) begin
                sel_valid = 1'b1;
                sel_cmd   = key_to_command(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        cmd_d   = cmd_q;
        case (state_q)
            S_IDLE: begin
                if (i_turnIndicator && sel_valid) begin
                    ready_d = 1'b1;
                    cmd_d   = sel_cmd;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_ack || !i_turnIndicator) begin
                    ready_d = 1'b0;
                    cmd_d   = `COMMAND_NONE;
                    state_d = (|pressed) ? S_RELEASE : S_IDLE;
                end
            end
            S_RELEASE: begin
                if (!(|pressed)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                cmd_d   = `COMMAND_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            cmd_q   <= `COMMAND_NONE;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cmd_q   <= cmd_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_command    = cmd_q;
    assign o_keyPressed = pressed;

endmodule

// File: tb/tb_user_input_debounced.sv
// Directed bench for user_input_debounced: a 2-key and a 4-key
// instance share clock, reset, turn and ack.
module tb_user_input_debounced;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_HIT   = 2'b01;
    localparam logic [1:0] C_STAND = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       turn;
    logic       ack;
    logic [1:0] key2;
    logic [3:0] key4;
    logic       rdy2;
    logic       rdy4;
    logic [1:0] cmd2;
    logic [1:0] cmd4;
    logic [1:0] kp2;
    logic [3:0] kp4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    user_input_debounced #(.NUM_KEYS(2), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_turnIndicator(turn),
        .i_KEY          (key2),
        .i_ack          (ack),
        .o_ready        (rdy2),
        .o_command      (cmd2),
        .o_keyPressed   (kp2)
    );

    user_input_debounced #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4)) dut4 (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_turnIndicator(turn),
        .i_KEY          (key4),
        .i_ack          (ack),
        .o_ready        (rdy4),
        .o_command      (cmd4),
        .o_keyPressed   (kp4)
    );

    // Advance n edges; inputs set afterwards are sampled at the next edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic watch2(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (rdy2) seen++;
        end
    endtask

    task automatic watch4(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (rdy4) seen++;
        end
    endtask

    task automatic settle();
        ack = 1'b1;
        tick(1);
        ack  = 1'b0;
        key2 = 2'b11;
        key4 = 4'b1111;
        turn = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        turn = 1'b0;
        ack  = 1'b0;
        key2 = 2'b11;
        key4 = 4'b1111;
        tick(3);
        rst = 1'b0;
        n_checks++;
        if (rdy2 !== 1'b0 || cmd2 !== C_NONE || kp2 !== 2'b00) begin
            n_fail++;
            $display("FAIL reset2: rdy=%b cmd=%b kp=%b want 0 00 00",
                     rdy2, cmd2, kp2);
        end
        n_checks++;
        if (rdy4 !== 1'b0 || cmd4 !== C_NONE || kp4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset4: rdy=%b cmd=%b kp=%b want 0 00 0000",
                     rdy4, cmd4, kp4);
        end
        tick(5);
    endtask

    task automatic test_single_press();
        int seen;
        turn = 1'b1;
        key2 = 2'b10;
        tick(6);
        n_checks++;
        if (rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: rdy=%b want 0", rdy2);
        end
        tick(1);
        n_checks++;
        if (rdy2 !== 1'b1 || cmd2 !== C_HIT) begin
            n_fail++;
            $display("FAIL single_ready: rdy=%b cmd=%b want 1 01", rdy2, cmd2);
        end
        tick(3);
        n_checks++;
        if (rdy2 !== 1'b1 || cmd2 !== C_HIT) begin
            n_fail++;
            $display("FAIL single_hold: rdy=%b cmd=%b want 1 01", rdy2, cmd2);
        end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        n_checks++;
        if (rdy2 !== 1'b0 || cmd2 !== C_NONE || kp2 !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ack: rdy=%b cmd=%b kp=%b want 0 00 01",
                     rdy2, cmd2, kp2);
        end
        watch2(20, seen);
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL single_held: ready cycles=%0d want 0", seen);
        end
        key2 = 2'b11;
        tick(8);
        n_checks++;
        if (kp2 !== 2'b00 || rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: kp=%b rdy=%b want 00 0", kp2, rdy2);
        end
        key2 = 2'b10;
        tick(7);
        n_checks++;
        if (rdy2 !== 1'b1 || cmd2 !== C_HIT) begin
            n_fail++;
            $display("FAIL single_repress: rdy=%b cmd=%b want 1 01", rdy2, cmd2);
        end
        settle();
    endtask

    task automatic test_bounce();
        int seen;
        int s;
        seen = 0;
        turn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key2 = 2'b01;
            watch2(2, s);
            seen += s;
            key2 = 2'b11;
            watch2(2, s);
            seen += s;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL bounce_glitch: ready cycles=%0d want 0", seen);
        end
        key2 = 2'b01;
        tick(6);
        n_checks++;
        if (rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_early: rdy=%b want 0", rdy2);
        end
        tick(1);
        n_checks++;
        if (rdy2 !== 1'b1 || cmd2 !== C_STAND) begin
            n_fail++;
            $display("FAIL bounce_cmd: rdy=%b cmd=%b want 1 10", rdy2, cmd2);
        end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        watch2(10, seen);
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL bounce_once: extra ready cycles=%0d want 0", seen);
        end
        settle();
    endtask

    task automatic test_simultaneous();
        int seen;
        turn = 1'b1;
        key2 = 2'b00;
        tick(7);
        n_checks++;
        if (rdy2 !== 1'b1 || cmd2 !== C_STAND) begin
            n_fail++;
            $display("FAIL simul_cmd: rdy=%b cmd=%b want 1 10", rdy2, cmd2);
        end
        ack = 1'b1;
        tick(1);
        ack  = 1'b0;
        key2 = 2'b11;
        watch2(15, seen);
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL simul_nohit: ready cycles=%0d want 0", seen);
        end
        settle();
    endtask

    task automatic test_turn_gating();
        int seen;
        turn = 1'b0;
        key2 = 2'b10;
        watch2(10, seen);
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL turn_off: ready cycles=%0d want 0", seen);
        end
        turn = 1'b1;
        watch2(10, seen);
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL turn_rise_held: ready cycles=%0d want 0", seen);
        end
        key2 = 2'b11;
        tick(8);
        key2 = 2'b10;
        tick(7);
        n_checks++;
        if (rdy2 !== 1'b1 || cmd2 !== C_HIT) begin
            n_fail++;
            $display("FAIL turn_press: rdy=%b cmd=%b want 1 01", rdy2, cmd2);
        end
        turn = 1'b0;
        tick(1);
        n_checks++;
        if (rdy2 !== 1'b0 || cmd2 !== C_NONE) begin
            n_fail++;
            $display("FAIL turn_drop: rdy=%b cmd=%b want 0 00", rdy2, cmd2);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        int seen;
        turn = 1'b1;
        key2 = 2'b10;
        tick(7);
        n_checks++;
        if (rdy2 !== 1'b1 || cmd2 !== C_HIT) begin
            n_fail++;
            $display("FAIL rstmid_pre: rdy=%b cmd=%b want 1 01", rdy2, cmd2);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++;
        if (rdy2 !== 1'b0 || cmd2 !== C_NONE || kp2 !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_vals: rdy=%b cmd=%b kp=%b want 0 00 00",
                     rdy2, cmd2, kp2);
        end
        watch2(20, seen);
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rstmid_held: ready cycles=%0d want 0", seen);
        end
        key2 = 2'b11;
        tick(8);
        key2 = 2'b10;
        tick(7);
        n_checks++;
        if (rdy2 !== 1'b1 || cmd2 !== C_HIT) begin
            n_fail++;
            $display("FAIL rstmid_repress: rdy=%b cmd=%b want 1 01", rdy2, cmd2);
        end
        settle();
    endtask

    task automatic test_four_keys();
        int seen;
        turn = 1'b1;
        key4 = 4'b0111;
        watch4(15, seen);
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL four_unmapped: ready cycles=%0d want 0", seen);
        end
        key4 = 4'b1111;
        tick(8);
        key4 = 4'b1001;
        tick(7);
        n_checks++;
        if (rdy4 !== 1'b1 || cmd4 !== C_STAND) begin
            n_fail++;
            $display("FAIL four_mixed: rdy=%b cmd=%b want 1 10", rdy4, cmd4);
        end
        n_checks++;
        if (kp4 !== 4'b0110) begin
            n_fail++;
            $display("FAIL four_level: kp=%b want 0110", kp4);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_turn_gating();
        test_reset_mid();
        test_four_keys();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
